// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int FWD_REGFILE = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  is_load;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: post-decode destination tracker with per-entry source
// match vectors for the decode operands and the captured execute operands.
module hazard_scoreboard #(
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int EX_DEPTH   = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic                  reg_write_i,
    input  logic                  is_load_i,
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    output logic [EX_DEPTH-1:0]   hit1_d_o,
    output logic [EX_DEPTH-1:0]   hit2_d_o,
    output logic [EX_DEPTH-1:0]   hit1_e_o,
    output logic [EX_DEPTH-1:0]   hit2_e_o,
    output logic [EX_DEPTH-1:0]   load_o
);
    import pipe_pkg::*;

    logic [EX_DEPTH-1:0]   vld_q, vld_d;
    logic [EX_DEPTH-1:0]   ld_q, ld_d;
    logic [REG_ADDR_W-1:0] ent_rd_q [EX_DEPTH];
    logic [REG_ADDR_W-1:0] ent_rd_d [EX_DEPTH];
    logic [REG_ADDR_W-1:0] rs1_e_q, rs2_e_q;
    logic                  live;

    assign live = valid_i && !flush_i;

    always_comb begin
        vld_d = {vld_q[EX_DEPTH-2:0], live && reg_write_i};
        ld_d  = {ld_q[EX_DEPTH-2:0], live && is_load_i};
        ent_rd_d[0] = rd_i;
        for (int k = 1; k < EX_DEPTH; k++) begin
            ent_rd_d[k] = ent_rd_q[k-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q   <= '0;
            ld_q    <= '0;
            rs1_e_q <= '0;
            rs2_e_q <= '0;
            for (int k = 0; k < EX_DEPTH; k++) begin
                ent_rd_q[k] <= '0;
            end
        end else begin
            vld_q    <= vld_d;
            ld_q     <= ld_d;
            ent_rd_q <= ent_rd_d;
            rs1_e_q  <= rs1_i;
            rs2_e_q  <= rs2_i;
        end
    end

    // x0 is hardwired, so it never matches a producer
    always_comb begin
        hit1_d_o = '0;
        hit2_d_o = '0;
        hit1_e_o = '0;
        hit2_e_o = '0;
        for (int k = 0; k < EX_DEPTH; k++) begin
            hit1_d_o[k] = vld_q[k] && ent_rd_q[k] == rs1_i && rs1_i != '0;
            hit2_d_o[k] = vld_q[k] && ent_rd_q[k] == rs2_i && rs2_i != '0;
            hit1_e_o[k] = vld_q[k] && ent_rd_q[k] == rs1_e_q && rs1_e_q != '0;
            hit2_e_o[k] = vld_q[k] && ent_rd_q[k] == rs2_e_q && rs2_e_q != '0;
        end
    end

    assign load_o = ld_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush and operand-forward control for the pipeline.
// Define FWD_EN to build the execute-stage forwarding network.
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_W = pipe_pkg::REG_ADDR_W,
    parameter int EX_DEPTH   = 3,
    parameter int FWD_W      = $clog2(EX_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  reg_write_d,
    input  logic                  is_load_d,
    input  logic                  pcsrc_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic [FWD_W-1:0]      fwd_a_e,
    output logic [FWD_W-1:0]      fwd_b_e
);
    import pipe_pkg::*;

    logic [EX_DEPTH-1:0] hit1_d, hit2_d, hit1_e, hit2_e, ld_v;
    logic [EX_DEPTH-1:0] block_m;
    logic                hazard;

    hazard_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .EX_DEPTH   (EX_DEPTH)
    ) u_sb (
        .clk_i       (clk),
        .rst_ni      (rst),
        .valid_i     (valid_d),
        .flush_i     (flush_e),
        .reg_write_i (reg_write_d),
        .is_load_i   (is_load_d),
        .rd_i        (rd_d),
        .rs1_i       (rs1_d),
        .rs2_i       (rs2_d),
        .hit1_d_o    (hit1_d),
        .hit2_d_o    (hit2_d),
        .hit1_e_o    (hit1_e),
        .hit2_e_o    (hit2_e),
        .load_o      (ld_v)
    );

`ifdef FWD_EN
    // Only loads too young to reach W by the consumer's execute cycle block.
    always_comb begin
        block_m = '0;
        for (int k = 0; k < EX_DEPTH; k++) begin
            block_m[k] = ld_v[k] && (k <= EX_DEPTH - 3);
        end
    end

    // Scan oldest to youngest so the youngest eligible producer wins.
    always_comb begin
        fwd_a_e = FWD_W'(FWD_REGFILE);
        fwd_b_e = FWD_W'(FWD_REGFILE);
        for (int k = EX_DEPTH - 1; k >= 1; k--) begin
            if (hit1_e[k] && (!ld_v[k] || k == EX_DEPTH - 1)) begin
                fwd_a_e = FWD_W'(k);
            end
            if (hit2_e[k] && (!ld_v[k] || k == EX_DEPTH - 1)) begin
                fwd_b_e = FWD_W'(k);
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{hit1_e, hit2_e, ld_v};

    // W is write-through, so every producer but the W entry blocks.
    always_comb begin
        block_m = '0;
        for (int k = 0; k < EX_DEPTH; k++) begin
            block_m[k] = (k <= EX_DEPTH - 2);
        end
    end

    assign fwd_a_e = FWD_W'(FWD_REGFILE);
    assign fwd_b_e = FWD_W'(FWD_REGFILE);
`endif

    assign hazard  = valid_d && |((hit1_d | hit2_d) & block_m);
    assign stall_f = rst && hazard && !pcsrc_e;
    assign stall_d = stall_f;
    assign flush_d = rst && pcsrc_e;
    assign flush_e = rst && (pcsrc_e || hazard);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table, reset corner cases and a
// randomized run against a stage-availability model of the hazard rules.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int D  = 3;
    localparam int RW = pipe_pkg::REG_ADDR_W;
    localparam int FW = $clog2(D);
    localparam int OW = 4 + 2 * FW;
`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_d;
    logic [RW-1:0] rs1_d, rs2_d, rd_d;
    logic          reg_write_d, is_load_d, pcsrc_e;
    logic          stall_f, stall_d, flush_d, flush_e;
    logic [FW-1:0] fwd_a_e, fwd_b_e;
    logic [OW-1:0] outs;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .REG_ADDR_W (RW),
        .EX_DEPTH   (D),
        .FWD_W      (FW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_d     (valid_d),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rd_d        (rd_d),
        .reg_write_d (reg_write_d),
        .is_load_d   (is_load_d),
        .pcsrc_e     (pcsrc_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .fwd_a_e     (fwd_a_e),
        .fwd_b_e     (fwd_b_e)
    );

    assign outs = {stall_f, stall_d, flush_d, flush_e, fwd_a_e, fwd_b_e};

    typedef struct {
        logic          v;
        logic [RW-1:0] rs1, rs2, rd;
        logic          wr, ld, pc;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int v, int rs1, int rs2, int rd, int wr,
                                int ld, int pc, int st, int fd, int fe,
                                int fa, int fb);
        vec_t t;
        t.v   = v != 0;
        t.rs1 = RW'(rs1);
        t.rs2 = RW'(rs2);
        t.rd  = RW'(rd);
        t.wr  = wr != 0;
        t.ld  = ld != 0;
        t.pc  = pc != 0;
        t.exp = {st != 0, st != 0, fd != 0, fe != 0, FW'(fa), FW'(fb)};
        return t;
    endfunction

    task automatic drive(input vec_t t);
        valid_d     = t.v;
        rs1_d       = t.rs1;
        rs2_d       = t.rs2;
        rd_d        = t.rd;
        reg_write_d = t.wr;
        is_load_d   = t.ld;
        pcsrc_e     = t.pc;
    endtask

    task automatic chk(input string nm, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b (sf sd fd fe fa fb)",
                      nm, act, exp);
    endtask

    // Model: a producer at entry k can feed an execute-stage consumer once
    // k >= min_src; a decode consumer reaches E when the producer is at k+1.
    sb_entry_t     m_sb [D];
    logic [RW-1:0] m_rs1e, m_rs2e;

    function automatic int min_src(sb_entry_t e);
        if (!FWD) return D;
        return e.is_load ? D - 1 : 1;
    endfunction

    function automatic bit hit(sb_entry_t e, logic [RW-1:0] r);
        return e.valid && e.rd == r && r != '0;
    endfunction

    function automatic logic [OW-1:0] model_out(vec_t t);
        bit haz;
        int fa, fb;
        haz = 1'b0;
        fa  = 0;
        fb  = 0;
        for (int k = 0; k < D; k++)
            if ((hit(m_sb[k], t.rs1) || hit(m_sb[k], t.rs2))
                && k + 1 < min_src(m_sb[k])) haz = 1'b1;
        haz = haz && t.v;
        for (int k = D - 1; k >= 1; k--) begin
            if (hit(m_sb[k], m_rs1e) && k >= min_src(m_sb[k])) fa = k;
            if (hit(m_sb[k], m_rs2e) && k >= min_src(m_sb[k])) fb = k;
        end
        return {haz && !t.pc, haz && !t.pc, t.pc, t.pc || haz,
                FW'(fa), FW'(fb)};
    endfunction

    task automatic model_step(vec_t t, logic fe);
        for (int k = D - 1; k >= 1; k--) m_sb[k] = m_sb[k-1];
        m_sb[0].valid   = t.v && !fe && t.wr;
        m_sb[0].rd      = t.rd;
        m_sb[0].is_load = t.ld;
        m_rs1e = t.rs1;
        m_rs2e = t.rs2;
    endtask

    initial begin
        vec_t          nop, cur;
        logic [OW-1:0] e;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef FWD_EN
        tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 3, 6, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0));
        tbl.push_back(mk(1, 6, 0, 7, 1, 1, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 1, 8, 1, 0, 0,  1, 0, 1, 2, 0));
        tbl.push_back(mk(1, 7, 1, 8, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 2, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 9, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 10, 11, 1, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 5, 12, 1, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 1));
`else
        tbl.push_back(mk(1, 1, 2, 5, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 3, 6, 1, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 3, 6, 1, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 3, 6, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 1, 8, 1, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 7, 1, 8, 1, 0, 0,  1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 7, 1, 8, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 9, 1, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 10, 1, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 10, 11, 1, 0, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0));
`endif

        // Reset holds every output low even with a branch pending.
        rst = 1'b0;
        drive(mk(1, 5, 5, 5, 1, 1, 1, 0, 0, 0, 0, 0));
        #1;
        chk("reset", outs, '0);
        @(negedge clk);
        drive(nop);
        rst = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk($sformatf("tbl%0d", i), outs, tbl[i].exp);
        end

        // Reset pulsed in the middle of a load-use stall.
        repeat (3) begin
            @(negedge clk);
            drive(nop);
        end
        @(negedge clk);
        drive(mk(1, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
        #1;
        chk("mr_lw", outs, '0);
        @(negedge clk);
        drive(mk(1, 5, 1, 7, 1, 0, 0, 1, 0, 1, 0, 0));
        #1;
        chk("mr_stall", outs, {1'b1, 1'b1, 1'b0, 1'b1, FW'(0), FW'(0)});
        #2;
        rst     = 1'b0;
        pcsrc_e = 1'b1;
        #1;
        chk("rst_async", outs, '0);
        @(negedge clk);
        pcsrc_e = 1'b0;
        rst     = 1'b1;
        #1;
        chk("rst_empty", outs, '0);
        @(negedge clk);
        drive(mk(1, 7, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        e = FWD ? '0 : {1'b1, 1'b1, 1'b0, 1'b1, FW'(0), FW'(0)};
        chk("rst_resume", outs, e);

        // Randomized traffic against the model.
        @(negedge clk);
        drive(nop);
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int k = 0; k < D; k++) m_sb[k] = '0;
        m_rs1e = '0;
        m_rs2e = '0;
        cur = nop;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            cur.pc = ($urandom_range(0, 7) == 0);
            drive(cur);
            #1;
            e = model_out(cur);
            chk($sformatf("rand%0d", n), outs, e);
            model_step(cur, e[OW-4]);
            if (!e[OW-1]) begin
                cur.v   = ($urandom_range(0, 4) != 0);
                cur.rs1 = RW'($urandom_range(0, 3));
                cur.rs2 = RW'($urandom_range(0, 3));
                cur.rd  = RW'($urandom_range(0, 3));
                cur.wr  = ($urandom_range(0, 4) != 0);
                cur.ld  = ($urandom_range(0, 2) == 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
